// File: rtl/pci_initiator_if.sv
// Local request port and PCI handshake signals shared by the initiator and its environment.
// AD and CBE are tri-stated, so they stay as plain ports on the initiator.
interface pci_initiator_if #(
  parameter int unsigned MAX_BURST = 4
);
  localparam int unsigned DW = MAX_BURST * 32;

  logic          REQ;
  logic [3:0]    REQ_CMD;
  logic [31:0]   REQ_ADDR;
  logic [2:0]    REQ_LEN;
  logic [3:0]    REQ_BE;
  logic [DW-1:0] WR_DATA;
  logic [DW-1:0] RD_DATA;
  logic          BUSY;
  logic          DONE;
  logic          ABORT;
  logic          FRAME;
  logic          IRDY;
  logic          TRDY;
  logic          DEVSEL;

  modport master (
    input  REQ, REQ_CMD, REQ_ADDR, REQ_LEN, REQ_BE, WR_DATA, TRDY, DEVSEL,
    output RD_DATA, BUSY, DONE, ABORT, FRAME, IRDY
  );

  modport slave (
    output REQ, REQ_CMD, REQ_ADDR, REQ_LEN, REQ_BE, WR_DATA, TRDY, DEVSEL,
    input  RD_DATA, BUSY, DONE, ABORT, FRAME, IRDY
  );
endinterface

// File: rtl/pci_initiator.sv
// PCI-style bus master: runs one local request as an address phase plus a data-phase burst,
// collecting read words into RD_DATA and ending in master abort when no target claims the bus.
module pci_initiator #(
  parameter int unsigned MAX_BURST      = 4,
  parameter int unsigned DEVSEL_TIMEOUT = 5,
  parameter logic [3:0]  READ_OP        = 4'b0110,
  parameter logic [3:0]  WRITE_OP       = 4'b0111
) (
  input  logic            CLK,
  input  logic            REST,
  pci_initiator_if.master bus,
  output wire  [3:0]      CBE,
  inout  wire  [31:0]     AD
);

  localparam int unsigned DW = MAX_BURST * 32;
  localparam int unsigned TW = $clog2(DEVSEL_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, TURN} state_e;

  state_e          state_q, state_d;
  logic            frame_q, frame_d;
  logic            irdy_q, irdy_d;
  logic [31:0]     ad_q, ad_d;
  logic            ad_oe_q, ad_oe_d;
  logic [3:0]      cbe_q, cbe_d;
  logic            cbe_oe_q, cbe_oe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            abort_q, abort_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic [2:0]      idx_q, idx_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [2:0]      len_q, len_d;
  logic [3:0]      be_q, be_d;
  logic            wr_q, wr_d;
  logic            rd_q, rd_d;
  logic            aborted_q, aborted_d;
  logic [2:0]      req_len_c;

  function automatic logic [31:0] word_at(input logic [DW-1:0] v, input logic [2:0] i);
    logic [31:0] w;
    w = '0;
    for (int unsigned k = 0; k < MAX_BURST; k++) begin
      if (i == 3'(k)) w = v[k*32 +: 32];
    end
    return w;
  endfunction

  // Requested length clamped to 1..MAX_BURST
  always_comb begin
    if (bus.REQ_LEN == 3'd0) begin
      req_len_c = 3'd1;
    end else if (32'(bus.REQ_LEN) > MAX_BURST) begin
      req_len_c = 3'(MAX_BURST);
    end else begin
      req_len_c = bus.REQ_LEN;
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    irdy_d    = irdy_q;
    ad_d      = ad_q;
    ad_oe_d   = ad_oe_q;
    cbe_d     = cbe_q;
    cbe_oe_d  = cbe_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    rd_data_d = rd_data_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    len_d     = len_q;
    be_d      = be_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    aborted_d = aborted_q;

    unique case (state_q)
      IDLE: begin
        if (bus.REQ) begin
          state_d   = ADDR;
          len_d     = req_len_c;
          be_d      = bus.REQ_BE;
          wr_d      = (bus.REQ_CMD == WRITE_OP);
          rd_d      = (bus.REQ_CMD == READ_OP);
          busy_d    = 1'b1;
          frame_d   = 1'b0;
          irdy_d    = 1'b1;
          ad_d      = bus.REQ_ADDR;
          ad_oe_d   = 1'b1;
          cbe_d     = bus.REQ_CMD;
          cbe_oe_d  = 1'b1;
          idx_d     = 3'd0;
          tmo_d     = '0;
          aborted_d = 1'b0;
        end
      end

      ADDR: begin
        state_d = DATA;
        irdy_d  = 1'b0;
        cbe_d   = be_q;
        frame_d = (len_q == 3'd1);
        ad_d    = word_at(bus.WR_DATA, 3'd0);
        ad_oe_d = wr_q;
      end

      DATA: begin
        if (bus.DEVSEL) begin
          // Nobody claimed the cycle yet: count towards master abort
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TW'(DEVSEL_TIMEOUT)) begin
            state_d   = TURN;
            frame_d   = 1'b1;
            irdy_d    = 1'b1;
            ad_oe_d   = 1'b0;
            cbe_oe_d  = 1'b0;
            aborted_d = 1'b1;
          end
        end else begin
          tmo_d = '0;
          if (!irdy_q && !bus.TRDY) begin
            if (rd_q) begin
              for (int unsigned k = 0; k < MAX_BURST; k++) begin
                if (idx_q == 3'(k)) rd_data_d[k*32 +: 32] = AD;
              end
            end
            idx_d = idx_q + 3'd1;
            if (idx_d == len_q) begin
              state_d  = TURN;
              frame_d  = 1'b1;
              irdy_d   = 1'b1;
              ad_oe_d  = 1'b0;
              cbe_oe_d = 1'b0;
            end else begin
              ad_d    = word_at(bus.WR_DATA, idx_d);
              frame_d = (idx_d == len_q - 3'd1);
            end
          end
        end
      end

      TURN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = !aborted_q;
        abort_d = aborted_q;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge REST) begin
    if (REST) begin
      state_q   <= IDLE;
      frame_q   <= 1'b1;
      irdy_q    <= 1'b1;
      ad_q      <= '0;
      ad_oe_q   <= 1'b0;
      cbe_q     <= '0;
      cbe_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      rd_data_q <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      len_q     <= 3'd1;
      be_q      <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      irdy_q    <= irdy_d;
      ad_q      <= ad_d;
      ad_oe_q   <= ad_oe_d;
      cbe_q     <= cbe_d;
      cbe_oe_q  <= cbe_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      rd_data_q <= rd_data_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      len_q     <= len_d;
      be_q      <= be_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.FRAME   = frame_q;
  assign bus.IRDY    = irdy_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.ABORT   = abort_q;
  assign bus.RD_DATA = rd_data_q;
  assign CBE         = cbe_oe_q ? cbe_q : 4'bz;
  assign AD          = ad_oe_q ? ad_q : 32'bz;

endmodule
